// File: rtl/sc_upc_pkg.sv
// Shared definitions for the microprogram sequencer: COND encodings,
// decode-address construction constants and field widths.
package sc_upc_pkg;

    localparam int unsigned COND_WIDTH     = 3;
    localparam int unsigned OP_WIDTH       = 2;
    localparam int unsigned OP3_WIDTH      = 6;
    localparam int unsigned CNT_WIDTH      = 16;
    localparam int unsigned DEC_ADDR_WIDTH = 11;

    localparam logic [COND_WIDTH-1:0] COND_NEXT   = 3'b000;
    localparam logic [COND_WIDTH-1:0] COND_JMP_N  = 3'b001;
    localparam logic [COND_WIDTH-1:0] COND_JMP_Z  = 3'b010;
    localparam logic [COND_WIDTH-1:0] COND_JMP_V  = 3'b011;
    localparam logic [COND_WIDTH-1:0] COND_JMP_C  = 3'b100;
    localparam logic [COND_WIDTH-1:0] COND_JMP_IR = 3'b101;
    localparam logic [COND_WIDTH-1:0] COND_JMP    = 3'b110;
    localparam logic [COND_WIDTH-1:0] COND_DECODE = 3'b111;

    localparam logic       DEC_PREFIX  = 1'b1;
    localparam logic [1:0] DEC_LOW_PAD = 2'b00;

    // Decode target: {1, op, op3, 00}, an 11-bit microstore address.
    function automatic logic [DEC_ADDR_WIDTH-1:0] decode_addr(
        input logic [OP_WIDTH-1:0]  op,
        input logic [OP3_WIDTH-1:0] op3
    );
        return {DEC_PREFIX, op, op3, DEC_LOW_PAD};
    endfunction

endpackage

// File: rtl/sc_upc_cond_eval.sv
// Branch-condition evaluator for the microprogram sequencer.
// Ports:
//   i_cond          COND field of the current microinstruction
//   i_n/i_z/i_v/i_c PSR condition flags
//   i_ir13          IR[13]
//   o_jump_true_c   conditional or unconditional jump whose condition holds
//   o_decode_c      COND selects decode
module sc_upc_cond_eval
    import sc_upc_pkg::*;
(
    input  logic [COND_WIDTH-1:0] i_cond,
    input  logic                  i_n,
    input  logic                  i_z,
    input  logic                  i_v,
    input  logic                  i_c,
    input  logic                  i_ir13,
    output logic                  o_jump_true_c,
    output logic                  o_decode_c
);

    // Jump-condition selection from COND.
    always_comb begin
        o_jump_true_c = 1'b0;
        o_decode_c    = 1'b0;
        case (i_cond)
            COND_JMP_N:  o_jump_true_c = i_n;
            COND_JMP_Z:  o_jump_true_c = i_z;
            COND_JMP_V:  o_jump_true_c = i_v;
            COND_JMP_C:  o_jump_true_c = i_c;
            COND_JMP_IR: o_jump_true_c = i_ir13;
            COND_JMP:    o_jump_true_c = 1'b1;
            COND_DECODE: o_decode_c    = 1'b1;
            default:     o_jump_true_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/sc_upc_sequencer.sv
// Microprogram sequencer: holds the micro-PC and selects next / jump /
// decode each cycle from COND, the PSR flags and IR bits.
// Ports:
//   SC_uPC_CLOCK_50       clock (rising edge)
//   SC_uPC_Reset_InHigh   synchronous active-high reset (priority over stall)
//   SC_uPC_Stall_InHigh   hold all state
//   SC_uPC_Cond           COND field
//   SC_uPC_JumpAddr       JUMP ADDR field
//   SC_uPC_IR_Op/Op3/Bit13 instruction-register fields for decode / IR[13] test
//   PSR_*_InHigh          N, Z, V, C flags
//   SC_uPC_Address        registered micro-PC
//   SC_uPC_Taken_InHigh   registered: last update loaded a jump/decode target
//   SC_uPC_TakenCount     saturating taken-transfer count
// Optional feature: SC_UPC_TAKEN_COUNT_EN enables the taken counter;
// without it SC_uPC_TakenCount is constant zero.
module sc_upc_sequencer
    import sc_upc_pkg::*;
#(
    parameter int unsigned UADDR_WIDTH = 11,
    parameter int unsigned UADDR_INIT  = 0
) (
    input  logic                   SC_uPC_CLOCK_50,
    input  logic                   SC_uPC_Reset_InHigh,
    input  logic                   SC_uPC_Stall_InHigh,
    input  logic [COND_WIDTH-1:0]  SC_uPC_Cond,
    input  logic [UADDR_WIDTH-1:0] SC_uPC_JumpAddr,
    input  logic [OP_WIDTH-1:0]    SC_uPC_IR_Op,
    input  logic [OP3_WIDTH-1:0]   SC_uPC_IR_Op3,
    input  logic                   SC_uPC_IR_Bit13,
    input  logic                   PSR_Negative_InHigh,
    input  logic                   PSR_Zero_InHigh,
    input  logic                   PSR_Overflow_InHigh,
    input  logic                   PSR_Carry_InHigh,
    output logic [UADDR_WIDTH-1:0] SC_uPC_Address,
    output logic                   SC_uPC_Taken_InHigh,
    output logic [CNT_WIDTH-1:0]   SC_uPC_TakenCount
);

    logic [UADDR_WIDTH-1:0] r_upc;
    logic                   r_taken;
    logic                   w_jump_true;
    logic                   w_decode;
    logic                   w_taken;
    logic [UADDR_WIDTH-1:0] w_upc_inc;
    logic [UADDR_WIDTH-1:0] w_dec_addr;
    logic [UADDR_WIDTH-1:0] w_upc_next;

    sc_upc_cond_eval u_cond_eval (
        .i_cond        (SC_uPC_Cond),
        .i_n           (PSR_Negative_InHigh),
        .i_z           (PSR_Zero_InHigh),
        .i_v           (PSR_Overflow_InHigh),
        .i_c           (PSR_Carry_InHigh),
        .i_ir13        (SC_uPC_IR_Bit13),
        .o_jump_true_c (w_jump_true),
        .o_decode_c    (w_decode)
    );

    assign w_taken    = w_jump_true | w_decode;
    assign w_upc_inc  = r_upc + UADDR_WIDTH'(1);
    assign w_dec_addr = UADDR_WIDTH'(decode_addr(SC_uPC_IR_Op, SC_uPC_IR_Op3));

    // Next-address mux.
    always_comb begin
        w_upc_next = w_upc_inc;
        if (w_decode) begin
            w_upc_next = w_dec_addr;
        end else if (w_jump_true) begin
            w_upc_next = SC_uPC_JumpAddr;
        end
    end

    // Micro-PC and taken flag; reset wins over stall.
    always_ff @(posedge SC_uPC_CLOCK_50) begin
        if (SC_uPC_Reset_InHigh) begin
            r_upc   <= UADDR_WIDTH'(UADDR_INIT);
            r_taken <= 1'b0;
        end else if (!SC_uPC_Stall_InHigh) begin
            r_upc   <= w_upc_next;
            r_taken <= w_taken;
        end
    end

    assign SC_uPC_Address      = r_upc;
    assign SC_uPC_Taken_InHigh = r_taken;

`ifdef SC_UPC_TAKEN_COUNT_EN
    logic [CNT_WIDTH-1:0] r_taken_cnt;

    // Saturating count of taken transfers.
    always_ff @(posedge SC_uPC_CLOCK_50) begin
        if (SC_uPC_Reset_InHigh) begin
            r_taken_cnt <= '0;
        end else if (!SC_uPC_Stall_InHigh && w_taken && (r_taken_cnt != '1)) begin
            r_taken_cnt <= r_taken_cnt + CNT_WIDTH'(1);
        end
    end

    assign SC_uPC_TakenCount = r_taken_cnt;
`else
    assign SC_uPC_TakenCount = '0;
`endif

endmodule

// File: tb/tb_sc_upc_sequencer.sv
// Self-checking bench for sc_upc_sequencer: directed scenarios plus random
// stimulus, compared every cycle against a behavioural model.
module tb_sc_upc_sequencer;

    localparam int unsigned W    = 11;
    localparam int unsigned INIT = 0;
`ifdef SC_UPC_TAKEN_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic [2:0]    cond;
    logic [W-1:0]  jaddr;
    logic [1:0]    op;
    logic [5:0]    op3;
    logic          ir13;
    logic          fn, fz, fv, fc;
    logic [W-1:0]  addr;
    logic          taken;
    logic [15:0]   cnt;

    int vectors     = 0;
    int miscompares = 0;

    int unsigned m_upc   = 0;
    int unsigned m_taken = 0;
    int unsigned m_cnt   = 0;

    sc_upc_sequencer #(.UADDR_WIDTH(W), .UADDR_INIT(INIT)) dut (
        .SC_uPC_CLOCK_50     (clk),
        .SC_uPC_Reset_InHigh (rst),
        .SC_uPC_Stall_InHigh (stall),
        .SC_uPC_Cond         (cond),
        .SC_uPC_JumpAddr     (jaddr),
        .SC_uPC_IR_Op        (op),
        .SC_uPC_IR_Op3       (op3),
        .SC_uPC_IR_Bit13     (ir13),
        .PSR_Negative_InHigh (fn),
        .PSR_Zero_InHigh     (fz),
        .PSR_Overflow_InHigh (fv),
        .PSR_Carry_InHigh    (fc),
        .SC_uPC_Address      (addr),
        .SC_uPC_Taken_InHigh (taken),
        .SC_uPC_TakenCount   (cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model update at each rising edge, then compare.
    always @(posedge clk) begin : model_cmp
        int unsigned tk;
        int unsigned tgt;
        if (rst) begin
            m_upc   = INIT;
            m_taken = 0;
            m_cnt   = 0;
        end else if (!stall) begin
            tk  = 0;
            tgt = (m_upc + 1) % (1 << W);
            if (cond == 3'd7) begin
                tk  = 1;
                tgt = (1 << 10) + (int'(op) << 8) + (int'(op3) << 2);
            end else if ((cond == 3'd1 && fn) || (cond == 3'd2 && fz) ||
                         (cond == 3'd3 && fv) || (cond == 3'd4 && fc) ||
                         (cond == 3'd5 && ir13) || (cond == 3'd6)) begin
                tk  = 1;
                tgt = int'(jaddr);
            end
            m_upc   = tgt;
            m_taken = tk;
            if (CNT_EN && tk == 1 && m_cnt < 65535) m_cnt = m_cnt + 1;
        end
        #1;
        vectors++;
        if (int'(addr) != m_upc || taken !== m_taken[0] || int'(cnt) != m_cnt ||
            $isunknown({addr, taken, cnt})) begin
            miscompares++;
            $display("FAIL model_cmp t=%0t addr=%h/%h taken=%b/%0d cnt=%0d/%0d",
                     $time, addr, m_upc, taken, m_taken, cnt, m_cnt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    initial begin : stim
        int unsigned c0;
        rst = 1'b1; stall = 1'b0; cond = 3'd0; jaddr = '0; op = '0; op3 = '0;
        ir13 = 1'b0; fn = 1'b0; fz = 1'b0; fv = 1'b0; fc = 1'b0;

        // Reset for two cycles, then count up.
        cyc(); cyc();
        check("rst_addr", int'(addr), 0);
        check("rst_taken", int'(taken), 0);
        check("rst_cnt", int'(cnt), 0);
        rst = 1'b0;
        cyc(); check("next1", int'(addr), 1);
        cyc(); check("next2", int'(addr), 2);
        cyc(); check("next3", int'(addr), 3);
        cyc(); cyc();
        check("at5", int'(addr), 5);

        // Conditional jumps from uPC=5; non-selected flags set opposite.
        for (int k = 1; k <= 5; k++) begin
            for (int v = 1; v >= 0; v--) begin
                fn   = (k == 1) ? v[0] : ~v[0];
                fz   = (k == 2) ? v[0] : ~v[0];
                fv   = (k == 3) ? v[0] : ~v[0];
                fc   = (k == 4) ? v[0] : ~v[0];
                ir13 = (k == 5) ? v[0] : ~v[0];
                cond = 3'(k); jaddr = 11'h200;
                cyc();
                check($sformatf("jmp%0d_v%0d_addr", k, v), int'(addr), (v != 0) ? 'h200 : 6);
                check($sformatf("jmp%0d_v%0d_taken", k, v), int'(taken), v);
                cond = 3'd6; jaddr = 11'd5;
                cyc();
            end
        end

        // Decode.
        cond = 3'd7; op = 2'b10; op3 = 6'b010000;
        cyc();
        check("decode_addr", int'(addr), 'h640);
        check("decode_taken", int'(taken), 1);

        // Wrap, then stall with an unconditional jump pending.
        cond = 3'd6; jaddr = 11'h7FF; cyc();
        cond = 3'd0; cyc();
        check("wrap_addr", int'(addr), 0);
        check("wrap_taken", int'(taken), 0);
        c0 = m_cnt;
        stall = 1'b1; cond = 3'd6; jaddr = 11'h055; cyc();
        check("stall_addr", int'(addr), 0);
        check("stall_taken", int'(taken), 0);
        check("stall_cnt", int'(cnt), int'(c0));
        stall = 1'b1; cond = 3'd7; cyc();
        check("stall_decode_addr", int'(addr), 0);

        // Reset beats stall.
        stall = 1'b0; cond = 3'd6; jaddr = 11'h123; cyc();
        check("at123", int'(addr), 'h123);
        stall = 1'b1; rst = 1'b1; cyc();
        check("rst_stall_addr", int'(addr), INIT);
        check("rst_stall_taken", int'(taken), 0);

        // Counter: 3 taken jumps, 2 not taken, 1 decode.
        stall = 1'b0; rst = 1'b0; fn = 1'b0;
        cond = 3'd6; jaddr = 11'h010;
        repeat (3) cyc();
        cond = 3'd1;
        repeat (2) cyc();
        cond = 3'd7;
        cyc();
        check("count4", int'(cnt), CNT_EN ? 4 : 0);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            stall = ($urandom_range(0, 4) == 0);
            cond  = 3'($urandom_range(0, 7));
            jaddr = W'($urandom);
            op    = 2'($urandom);
            op3   = 6'($urandom);
            ir13  = 1'($urandom);
            fn    = 1'($urandom);
            fz    = 1'($urandom);
            fv    = 1'($urandom);
            fc    = 1'($urandom);
            cyc();
        end

`ifdef SC_UPC_TAKEN_COUNT_EN
        // Saturation: more than 65535 taken transfers.
        rst = 1'b1; stall = 1'b0; cyc();
        rst = 1'b0; cond = 3'd6; jaddr = 11'h001;
        repeat (65540) cyc();
        check("count_sat", int'(cnt), 'hFFFF);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
